bubble_sort_seq: RTL and testbench

Sequential sorting engine that produces the ordered array for the team's compare-swap network. It accepts DIM unsigned words as a serial stream and sorts them in place with odd-even transposition passes built from the team's pair compare-swap cell. It then streams the words out in ascending order. It sits between a word producer and a consumer, and replaces the combinational sorting chain where area matters more than latency.

---
 rtl/bubble_sort_pkg.sv | 24 ++
 rtl/bubble_sort_seq_pair_swap.sv | 17 +
 rtl/bubble_sort_seq.sv | 142 ++++++++++++++
 tb/tb_bubble_sort_seq.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/bubble_sort_pkg.sv
// Shared types and helpers for the serial odd-even transposition sorter.
package bubble_sort_pkg;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    SORT  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Smallest k with 2**k >= n; constant-evaluable for parameter sizing.
  function automatic int ceil_log2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < n) begin
        r = i + 1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/bubble_sort_seq_pair_swap.sv
// Combinational compare-exchange cell: lo gets the smaller word, hi the larger.
module pair_swap #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);

  logic swap_s;

  assign swap_s = (a > b);
  assign lo     = swap_s ? b : a;
  assign hi     = swap_s ? a : b;

endmodule

// File: rtl/bubble_sort_seq.sv
// Serial-in, serial-out sorter: load DIM words, run DIM odd-even transposition
// phases in place, then stream the buffer out in ascending order.
module bubble_sort_seq
  import bubble_sort_pkg::*;
#(
  parameter int DIM   = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             busy
);

  localparam int CW    = ceil_log2(DIM + 1);
  localparam int IW    = ceil_log2(DIM);
  localparam int NE    = DIM / 2;
  localparam int NO    = (DIM - 1) / 2;
  localparam int NO_SZ = (NO > 0) ? NO : 1;

  state_t           state_r;
  logic [CW-1:0]    wr_idx_r;
  logic [CW-1:0]    rd_idx_r;
  logic [CW-1:0]    phase_r;
  logic [WIDTH-1:0] buf_r      [DIM];
  logic [WIDTH-1:0] sort_nxt_s [DIM];

  logic [WIDTH-1:0] ev_lo_s [NE];
  logic [WIDTH-1:0] ev_hi_s [NE];
  logic [WIDTH-1:0] od_lo_s [NO_SZ];
  logic [WIDTH-1:0] od_hi_s [NO_SZ];

  for (genvar i = 0; i < NE; i++) begin : g_even
    pair_swap #(.WIDTH(WIDTH)) u_swap (
      .a  (buf_r[2*i]),
      .b  (buf_r[2*i+1]),
      .lo (ev_lo_s[i]),
      .hi (ev_hi_s[i])
    );
  end

  for (genvar i = 0; i < NO; i++) begin : g_odd
    pair_swap #(.WIDTH(WIDTH)) u_swap (
      .a  (buf_r[2*i+1]),
      .b  (buf_r[2*i+2]),
      .lo (od_lo_s[i]),
      .hi (od_hi_s[i])
    );
  end

  if (NO == 0) begin : g_no_odd
    assign od_lo_s[0] = '0;
    assign od_hi_s[0] = '0;
  end

  // Phase parity picks the pair set; an unpaired end index keeps its word.
  always_comb begin
    for (int j = 0; j < DIM; j++) begin
      sort_nxt_s[j] = buf_r[j];
    end
    if (phase_r[0] == 1'b0) begin
      for (int i = 0; i < NE; i++) begin
        sort_nxt_s[2*i]   = ev_lo_s[i];
        sort_nxt_s[2*i+1] = ev_hi_s[i];
      end
    end else begin
      for (int i = 0; i < NO; i++) begin
        sort_nxt_s[2*i+1] = od_lo_s[i];
        sort_nxt_s[2*i+2] = od_hi_s[i];
      end
    end
  end

  // FSM, counters and buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= LOAD;
      wr_idx_r <= '0;
      rd_idx_r <= '0;
      phase_r  <= '0;
      for (int j = 0; j < DIM; j++) begin
        buf_r[j] <= '0;
      end
    end else begin
      case (state_r)
        LOAD: begin
          if (in_valid) begin
            buf_r[wr_idx_r[IW-1:0]] <= in_data;
            if (wr_idx_r == CW'(DIM - 1)) begin
              state_r  <= SORT;
              wr_idx_r <= '0;
              phase_r  <= '0;
            end else begin
              wr_idx_r <= wr_idx_r + CW'(1);
            end
          end
        end
        SORT: begin
          for (int j = 0; j < DIM; j++) begin
            buf_r[j] <= sort_nxt_s[j];
          end
          if (phase_r == CW'(DIM - 1)) begin
            state_r  <= DRAIN;
            rd_idx_r <= '0;
            phase_r  <= '0;
          end else begin
            phase_r <= phase_r + CW'(1);
          end
        end
        DRAIN: begin
          if (out_ready) begin
            if (rd_idx_r == CW'(DIM - 1)) begin
              state_r  <= LOAD;
              rd_idx_r <= '0;
            end else begin
              rd_idx_r <= rd_idx_r + CW'(1);
            end
          end
        end
        default: begin
          state_r  <= LOAD;
          wr_idx_r <= '0;
          rd_idx_r <= '0;
          phase_r  <= '0;
        end
      endcase
    end
  end

  assign in_ready  = (state_r == LOAD);
  assign out_valid = (state_r == DRAIN);
  assign busy      = (state_r == SORT) || (state_r == DRAIN);
  assign out_last  = (state_r == DRAIN) && (rd_idx_r == CW'(DIM - 1));
  assign out_data  = buf_r[rd_idx_r[IW-1:0]];

endmodule

// File: tb/tb_bubble_sort_seq.sv
// Directed bench for bubble_sort_seq: DIM=4 vector table plus stall, reset
// and held-valid sequences, and a DIM=5 instance for the unpaired index.
module tb_bubble_sort_seq;

  typedef logic [0:3][7:0] word4_t;
  typedef logic [0:4][7:0] word5_t;
  typedef struct {
    word4_t      din;
    word4_t      dexp;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1, out_last, busy;
  logic [7:0] in_data = 8'd0, out_data;
  logic       in_valid_5 = 1'b0, in_ready_5, out_valid_5, out_ready_5 = 1'b1, out_last_5, busy_5;
  logic [7:0] in_data_5 = 8'd0, out_data_5;

  int checks = 0;
  int passes = 0;
  logic hold_valid = 1'b0;

  always #5 clk = ~clk;

  bubble_sort_seq #(.DIM(4), .WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy)
  );

  bubble_sort_seq #(.DIM(5), .WIDTH(8)) dut5 (
    .clk(clk), .rst(rst), .in_valid(in_valid_5), .in_ready(in_ready_5), .in_data(in_data_5),
    .out_valid(out_valid_5), .out_ready(out_ready_5), .out_data(out_data_5),
    .out_last(out_last_5), .busy(busy_5)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Loads v[first..3]; returns cycles from the last transfer cycle to first out_valid.
  task automatic load_words(input word4_t v, input int first, output int lat);
    for (int k = first; k < 4; k++) begin
      int b = 0;
      in_valid = 1'b1;
      in_data  = v[k];
      while (!in_ready && b < 50) begin
        tick();
        b++;
      end
      if (b >= 50) check("load_timeout", 32'd0, 32'd1);
      tick();
    end
    in_valid = hold_valid;
    in_data  = 8'hEE;
    lat = 1;
    check("sort_in_ready", {31'd0, in_ready}, 32'd0);
    check("sort_busy", {31'd0, busy}, 32'd1);
    while (!out_valid && lat < 100) begin
      tick();
      lat++;
    end
    if (lat >= 100) check("sort_timeout", 32'd0, 32'd1);
  endtask

  // Drains four words, optionally stalling with out_ready pattern 1,0,0,1.
  task automatic drain_check(input word4_t e, input bit toggle, input string tag);
    int cyc = 0;
    for (int k = 0; k < 4; k++) begin
      bit r;
      int b = 0;
      do begin
        r = toggle ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
        out_ready = r;
        check({tag, "_data"}, {24'd0, out_data}, {24'd0, e[k]});
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        if (r) check({tag, "_last"}, {31'd0, out_last}, {31'd0, (k == 3)});
        tick();
        cyc++;
        b++;
      end while (!r && b < 20);
    end
    out_ready = 1'b1;
    check({tag, "_post_in_ready"}, {31'd0, in_ready}, 32'd1);
    check({tag, "_post_out_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_post_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    vec_t   tbl[4];
    int     lat;
    word5_t v5, e5;

    tbl[0] = '{din: '{8'd4, 8'd3, 8'd2, 8'd1},     dexp: '{8'd1, 8'd2, 8'd3, 8'd4}};
    tbl[1] = '{din: '{8'd7, 8'd7, 8'd0, 8'd7},     dexp: '{8'd0, 8'd7, 8'd7, 8'd7}};
    tbl[2] = '{din: '{8'd1, 8'd2, 8'd3, 8'd4},     dexp: '{8'd1, 8'd2, 8'd3, 8'd4}};
    tbl[3] = '{din: '{8'd255, 8'd0, 8'd128, 8'd0}, dexp: '{8'd0, 8'd0, 8'd128, 8'd255}};

    repeat (2) tick();
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_last", {31'd0, out_last}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_out_data", {24'd0, out_data}, 32'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 4; i++) begin
      load_words(tbl[i].din, 0, lat);
      check("latency", lat, 32'd5);
      drain_check(tbl[i].dexp, 1'b0, "vec");
    end

    // Stalled drain with in_valid held high through SORT and DRAIN.
    hold_valid = 1'b1;
    load_words('{8'd40, 8'd10, 8'd30, 8'd20}, 0, lat);
    drain_check('{8'd10, 8'd20, 8'd30, 8'd40}, 1'b1, "stall");
    hold_valid = 1'b0;
    tick();  // the held 0xEE is the first word of the next batch
    load_words('{8'hEE, 8'd1, 8'd2, 8'd3}, 1, lat);
    drain_check('{8'd1, 8'd2, 8'd3, 8'hEE}, 1'b0, "held");

    // Reset in the middle of DRAIN.
    load_words('{8'd8, 8'd6, 8'd7, 8'd5}, 0, lat);
    check("mid_d0", {24'd0, out_data}, 32'd5);
    tick();
    check("mid_d1", {24'd0, out_data}, 32'd6);
    tick();
    rst = 1'b1;
    tick();
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    tick();
    load_words('{8'd9, 8'd5, 8'd6, 8'd1}, 0, lat);
    drain_check('{8'd1, 8'd5, 8'd6, 8'd9}, 1'b0, "fresh");

    // DIM=5 instance: odd count leaves one index unpaired each phase.
    v5 = '{8'd5, 8'd1, 8'd4, 8'd2, 8'd3};
    e5 = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5};
    for (int k = 0; k < 5; k++) begin
      in_valid_5 = 1'b1;
      in_data_5  = v5[k];
      check("d5_in_ready", {31'd0, in_ready_5}, 32'd1);
      tick();
    end
    in_valid_5 = 1'b0;
    lat = 1;
    while (!out_valid_5 && lat < 100) begin
      tick();
      lat++;
    end
    check("d5_latency", lat, 32'd6);
    for (int k = 0; k < 5; k++) begin
      check("d5_data", {24'd0, out_data_5}, {24'd0, e5[k]});
      check("d5_last", {31'd0, out_last_5}, {31'd0, (k == 4)});
      tick();
    end
    check("d5_post_in_ready", {31'd0, in_ready_5}, 32'd1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
